edge_rs_dispatch: RTL and testbench

//  Receive end of the edge-buffer -> RS stream. Accepts one packet per cycle from the edge

---
 rtl/edge_rs_dispatch.sv | 192 +++++++++++++++++++
 tb/tb_edge_rs_dispatch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_rs_dispatch.sv
// edge_rs_dispatch: receive end of the edge-buffer -> RS packet stream.
// Buffers accepted packets in a FIFO and raises rs_busy back-pressure near full.
// Dispatches buffered packets round-robin to idle PEs and tracks sos/eos framing.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   in_valid/in_pkt incoming packet {sos, eos, payload}
//   rs_busy         registered back-pressure to the edge-buffer arbiter
//   pe_idle         per-PE ready
//   pe_valid/pe_pkt registered one-hot dispatch strobe and shared packet bus
//   stream_done     one-cycle pulse once the eos packet is dispatched and the FIFO is empty
//   overflow_err    sticky, packet dropped because the FIFO was full
//   proto_err       sticky, non-sos packet dropped while idle
module edge_rs_dispatch #(
   parameter int unsigned NUM_PE   = 4,
   parameter int unsigned PKT_W    = 34,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned HEADROOM = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [PKT_W-1:0]  in_pkt,
   output logic              rs_busy,
   input  logic [NUM_PE-1:0] pe_idle,
   output logic [NUM_PE-1:0] pe_valid,
   output logic [PKT_W-1:0]  pe_pkt,
   output logic              stream_done,
   output logic              overflow_err,
   output logic              proto_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] BUSY_CNT = CNT_W'(DEPTH - HEADROOM);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   logic [PKT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [PE_W-1:0]   r_rr;
   logic              r_eos_sent;
   state_t            r_state;
   logic              r_rs_busy;
   logic [NUM_PE-1:0] r_pe_valid;
   logic [PKT_W-1:0]  r_pe_pkt;
   logic              r_stream_done;
   logic              r_overflow_err;
   logic              r_proto_err;

   state_t            w_state_next;
   logic              w_done;
   logic              w_sos;
   logic              w_eos;
   logic              w_full;
   logic              w_empty;
   logic              w_drop_full;
   logic              w_drop_proto;
   logic              w_wr;
   logic              w_rd;
   logic              w_found;
   logic [NUM_PE-1:0] w_elig;
   logic [NUM_PE-1:0] w_grant_oh;
   logic [PE_W-1:0]   w_rr_next;
   logic [CNT_W-1:0]  w_count_next;
   logic [PKT_W-1:0]  w_head;

   assign w_sos   = in_pkt[PKT_W-1];
   assign w_eos   = in_pkt[PKT_W-2];
   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

   // Full takes precedence over the framing check when both would drop.
   assign w_drop_full  = in_valid && w_full;
   assign w_drop_proto = in_valid && !w_full && (r_state == ST_IDLE) && !w_sos;
   assign w_wr         = in_valid && !w_drop_full && !w_drop_proto;

   // A PE strobed last cycle is still busy with that packet.
   assign w_elig = pe_idle & ~r_pe_valid;

   // Round-robin: first eligible PE at or after the rr pointer, wrapping.
   always_comb begin
      int unsigned v_idx;
      v_idx      = 0;
      w_found    = 1'b0;
      w_grant_oh = '0;
      w_rr_next  = r_rr;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         v_idx = (32'(r_rr) + k) % NUM_PE;
         if (!w_found && w_elig[PE_W'(v_idx)]) begin
            w_found                  = 1'b1;
            w_grant_oh[PE_W'(v_idx)] = 1'b1;
            w_rr_next                = PE_W'((v_idx + 1) % NUM_PE);
         end
      end
   end

   assign w_rd = w_found && !w_empty;

   // Occupancy after this cycle's write and read.
   always_comb begin
      w_count_next = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Framing FSM next state; DRAIN ends once eos has left and nothing remains or arrives.
   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr) w_state_next = w_eos ? ST_DRAIN : ST_STREAM;
         end
         ST_STREAM: begin
            if (w_wr && w_eos) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_eos_sent && w_empty && !w_wr) begin
               w_state_next = ST_IDLE;
               w_done       = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM state register and completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_stream_done <= 1'b0;
         r_eos_sent    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_stream_done <= w_done;
         if (w_done)                        r_eos_sent <= 1'b0;
         else if (w_rd && w_head[PKT_W-2])  r_eos_sent <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= in_pkt;
   end

   // FIFO pointers, dispatch registers and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_rr           <= '0;
         r_rs_busy      <= 1'b0;
         r_pe_valid     <= '0;
         r_pe_pkt       <= '0;
         r_overflow_err <= 1'b0;
         r_proto_err    <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_rr     <= w_rr_next;
            r_pe_pkt <= w_head;
         end
         r_pe_valid <= w_rd ? w_grant_oh : '0;
         r_count    <= w_count_next;
         r_rs_busy  <= (w_count_next >= BUSY_CNT);
         if (w_drop_full)  r_overflow_err <= 1'b1;
         if (w_drop_proto) r_proto_err    <= 1'b1;
      end
   end

   assign rs_busy      = r_rs_busy;
   assign pe_valid     = r_pe_valid;
   assign pe_pkt       = r_pe_pkt;
   assign stream_done  = r_stream_done;
   assign overflow_err = r_overflow_err;
   assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_edge_rs_dispatch.sv
// Bench for edge_rs_dispatch: directed sequences with a packet scoreboard on the dispatch side.
module tb_edge_rs_dispatch;

   localparam int unsigned NUM_PE = 4;
   localparam int unsigned PKT_W  = 34;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [PKT_W-1:0]  in_pkt;
   logic              rs_busy;
   logic [NUM_PE-1:0] pe_idle;
   logic [NUM_PE-1:0] pe_valid;
   logic [PKT_W-1:0]  pe_pkt;
   logic              stream_done;
   logic              overflow_err;
   logic              proto_err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   logic [PKT_W-1:0] sb [$];
   logic [PKT_W-1:0] exp_pkt;

   edge_rs_dispatch #(.NUM_PE(NUM_PE), .PKT_W(PKT_W), .DEPTH(8), .HEADROOM(2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_pkt       (in_pkt),
      .rs_busy      (rs_busy),
      .pe_idle      (pe_idle),
      .pe_valid     (pe_valid),
      .pe_pkt       (pe_pkt),
      .stream_done  (stream_done),
      .overflow_err (overflow_err),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Dispatched packets must come out one-hot and in acceptance order.
   always @(negedge clk) begin
      if (reset) begin
         if (stream_done) n_done++;
         if (pe_valid != '0) begin
            chk("pe_onehot", 64'($countones(pe_valid)), 64'd1);
            if (sb.size() == 0) begin
               chk("sb_extra_valid", 64'(pe_valid), 64'd0);
            end else begin
               exp_pkt = sb.pop_front();
               chk("sb_pkt", 64'(pe_pkt), 64'(exp_pkt));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic send(input logic s, input logic e, input logic acc);
      logic [PKT_W-1:0] p;
      p = {s, e, (PKT_W-2)'($urandom)};
      in_valid = 1'b1;
      in_pkt   = p;
      if (acc) sb.push_back(p);
      step();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      pe_idle  = '0;
      reset    = 1'b0;
      repeat (2) step();
      sb.delete();
      n_done = 0;
      reset  = 1'b1;
      step();
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < max_cyc) begin
         step();
         n++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with traffic present: all outputs stay low.
      reset    = 1'b0;
      in_valid = 1'b1;
      in_pkt   = {1'b1, 1'b0, 32'h1234_5678};
      pe_idle  = '1;
      repeat (3) step();
      chk("rst_busy",  64'(rs_busy), 64'd0);
      chk("rst_valid", 64'(pe_valid), 64'd0);
      chk("rst_pkt",   64'(pe_pkt), 64'd0);
      chk("rst_done",  64'(stream_done), 64'd0);
      chk("rst_ovf",   64'(overflow_err), 64'd0);
      chk("rst_proto", 64'(proto_err), 64'd0);
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) step();
      chk("rst_empty_valid", 64'(pe_valid), 64'd0);
      chk("rst_empty_busy",  64'(rs_busy), 64'd0);

      // Single stream sos, P1, eos with all PEs idle.
      do_reset();
      pe_idle = '1;
      send(1'b1, 1'b0, 1'b1);
      chk("s_c1_valid", 64'(pe_valid), 64'd0);
      send(1'b0, 1'b0, 1'b1);
      chk("s_c2_valid", 64'(pe_valid), 64'b0001);
      send(1'b0, 1'b1, 1'b1);
      chk("s_c3_valid", 64'(pe_valid), 64'b0010);
      idle(1);
      chk("s_c4_valid", 64'(pe_valid), 64'b0100);
      chk("s_c4_done",  64'(stream_done), 64'd0);
      idle(1);
      chk("s_c5_done",  64'(stream_done), 64'd1);
      chk("s_c5_valid", 64'(pe_valid), 64'd0);
      idle(1);
      chk("s_c6_done",  64'(stream_done), 64'd0);

      // Back-pressure and overflow with PEs stalled, then in-order drain.
      do_reset();
      pe_idle = '0;
      for (int i = 1; i <= 6; i++) begin
         send(i == 1, 1'b0, 1'b1);
         chk("bp_busy", 64'(rs_busy), 64'(i >= 6));
      end
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b1);
      chk("bp_full_busy", 64'(rs_busy), 64'd1);
      chk("bp_full_ovf",  64'(overflow_err), 64'd0);
      send(1'b0, 1'b0, 1'b0);
      chk("bp_ovf", 64'(overflow_err), 64'd1);
      pe_idle = '1;
      wait_drain(40);
      idle(3);
      chk("bp_done_cnt", 64'(n_done), 64'd1);
      chk("bp_busy_low", 64'(rs_busy), 64'd0);
      chk("bp_ovf_sticky", 64'(overflow_err), 64'd1);

      // Round-robin over PEs 1 and 3 only.
      do_reset();
      pe_idle = '0;
      send(1'b1, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b1);
      chk("rr_hold", 64'(pe_valid), 64'd0);
      pe_idle = 4'b1010;
      idle(1);
      chk("rr_0", 64'(pe_valid), 64'b0010);
      idle(1);
      chk("rr_1", 64'(pe_valid), 64'b1000);
      idle(1);
      chk("rr_2", 64'(pe_valid), 64'b0010);
      idle(1);
      chk("rr_3", 64'(pe_valid), 64'b1000);
      idle(1);
      chk("rr_done", 64'(stream_done), 64'd1);
      chk("rr_sb", 64'(sb.size()), 64'd0);

      // Non-sos while idle is dropped; then a one-packet sos+eos stream.
      do_reset();
      pe_idle = '1;
      send(1'b0, 1'b0, 1'b0);
      idle(1);
      chk("pr_err", 64'(proto_err), 64'd1);
      chk("pr_valid0", 64'(pe_valid), 64'd0);
      idle(1);
      chk("pr_valid1", 64'(pe_valid), 64'd0);
      send(1'b1, 1'b1, 1'b1);
      idle(1);
      chk("pr_one_valid", 64'(pe_valid), 64'b0001);
      idle(1);
      chk("pr_one_done", 64'(stream_done), 64'd1);

      // Simultaneous push/pop at DEPTH-1 keeps occupancy constant.
      do_reset();
      pe_idle = '0;
      for (int i = 0; i < 7; i++) send(i == 0, 1'b0, 1'b1);
      chk("pp_busy_pre", 64'(rs_busy), 64'd1);
      pe_idle = '1;
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 1'b0, 1'b1);
         chk("pp_busy", 64'(rs_busy), 64'd1);
         chk("pp_ovf",  64'(overflow_err), 64'd0);
         chk("pp_pop",  64'(pe_valid != '0), 64'd1);
      end
      pe_idle = '0;
      send(1'b0, 1'b0, 1'b1);
      chk("pp_last_ovf", 64'(overflow_err), 64'd0);
      send(1'b0, 1'b0, 1'b0);
      chk("pp_drop_ovf", 64'(overflow_err), 64'd1);
      pe_idle = '1;
      wait_drain(40);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
